// File: rtl/invaders_io_pkg.sv
// rtl/invaders_io_pkg.sv - shared port map and FSM state type for the I/O bridge
//
// Purpose: port-number constants for the arcade I/O map and the bus-cycle
//          state enum used by invaders_io_bridge.
// Ports:   none (package).
package invaders_io_pkg;

  // IN ports
  localparam logic [7:0] PORT_IN0       = 8'd0;
  localparam logic [7:0] PORT_IN1       = 8'd1;
  localparam logic [7:0] PORT_IN2       = 8'd2;
  localparam logic [7:0] PORT_SHIFT_RD  = 8'd3;

  // OUT ports
  localparam logic [7:0] PORT_SHIFT_OFS = 8'd2;
  localparam logic [7:0] PORT_SND1      = 8'd3;
  localparam logic [7:0] PORT_SHIFT_DAT = 8'd4;
  localparam logic [7:0] PORT_SND2      = 8'd5;
  localparam logic [7:0] PORT_WDOG      = 8'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_EXEC,
    ST_ACK,
    ST_WAIT
  } io_state_e;

endpackage

// File: rtl/io_sync.sv
// rtl/io_sync.sv - two-flop synchronizer for asynchronous cabinet inputs
//
// Purpose: brings a bus of asynchronous levels into the i_clk domain.
// Ports:   i_clk   - destination clock
//          i_rst_n - asynchronous active-low reset (clears both stages)
//          i_d     - asynchronous input bus
//          o_q     - synchronized output bus (2 edges of latency)
module io_sync #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/invaders_io_bridge.sv
// rtl/invaders_io_bridge.sv - 8080 IN/OUT port controller: shifter, inputs, sound, watchdog
//
// Purpose: decodes CPU I/O bus cycles, strobes the bitshift unit, muxes IN data,
//          latches the sound ports and runs the watchdog.
// Ports:   i_clk, i_rst_n                 - clock, async active-low reset
//          i_io_req/i_io_wr/i_io_port/i_io_wdata - CPU I/O request (level, held until ack)
//          o_io_ack, o_io_rdata           - one-cycle ack, IN data (held until next read)
//          i_in0..i_in2                   - raw asynchronous cabinet inputs
//          o_shift_wr_data/o_shift_wr_offset/o_shift_data - shifter write interface
//          i_shift_rdata                  - shifter result
//          o_snd1/o_snd2, o_snd1_rise/o_snd2_rise - sound latches and 0->1 pulses
//          o_wdog_reset                   - one-cycle watchdog expiry pulse
module invaders_io_bridge
  import invaders_io_pkg::*;
#(
  parameter int WDOG_BITS = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_io_req,
  input  logic       i_io_wr,
  input  logic [7:0] i_io_port,
  input  logic [7:0] i_io_wdata,
  output logic       o_io_ack,
  output logic [7:0] o_io_rdata,
  input  logic [7:0] i_in0,
  input  logic [7:0] i_in1,
  input  logic [7:0] i_in2,
  output logic       o_shift_wr_data,
  output logic       o_shift_wr_offset,
  output logic [7:0] o_shift_data,
  input  logic [7:0] i_shift_rdata,
  output logic [7:0] o_snd1,
  output logic [7:0] o_snd2,
  output logic [7:0] o_snd1_rise,
  output logic [7:0] o_snd2_rise,
  output logic       o_wdog_reset
);

  // Terminal count 2^W-2 gives a period of 2^W-1 cycles (0..2^W-2).
  localparam logic [WDOG_BITS-1:0] WDOG_TC  = {{(WDOG_BITS-1){1'b1}}, 1'b0};
  localparam logic [WDOG_BITS-1:0] WDOG_ONE = {{(WDOG_BITS-1){1'b0}}, 1'b1};

  io_state_e r_state, w_state_nxt;

  logic [7:0]  r_port;
  logic        r_wr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic [7:0]  r_snd1, r_snd2;
  logic [7:0]  r_snd1_rise, r_snd2_rise;
  logic [WDOG_BITS-1:0] r_wdog_cnt;
  logic        r_wdog_pulse;

  logic [23:0] w_in_sync;
  logic [7:0]  w_rdata_mux;
  logic        w_exec_wr;
  logic        w_exec_rd;
  logic        w_kick;

  io_sync #(.WIDTH(24)) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    ({i_in2, i_in1, i_in0}),
    .o_q    (w_in_sync)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_io_req) w_state_nxt = ST_LATCH;
      ST_LATCH: w_state_nxt = ST_EXEC;
      ST_EXEC:  w_state_nxt = ST_ACK;
      // A request still high after ACK parks in WAIT so it is never re-executed.
      ST_ACK:   w_state_nxt = i_io_req ? ST_WAIT : ST_IDLE;
      ST_WAIT:  if (!i_io_req) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  assign w_exec_wr = (r_state == ST_EXEC) &&  r_wr;
  assign w_exec_rd = (r_state == ST_EXEC) && !r_wr;
  assign w_kick    = w_exec_wr && (r_port == PORT_WDOG);

  always_comb begin
    w_rdata_mux = 8'h00;
    case (r_port)
      PORT_IN0:      w_rdata_mux = w_in_sync[7:0];
      PORT_IN1:      w_rdata_mux = w_in_sync[15:8];
      PORT_IN2:      w_rdata_mux = w_in_sync[23:16];
      PORT_SHIFT_RD: w_rdata_mux = i_shift_rdata;
      default:       w_rdata_mux = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_port      <= '0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_snd1      <= '0;
      r_snd2      <= '0;
      r_snd1_rise <= '0;
      r_snd2_rise <= '0;
    end else begin
      if (r_state == ST_LATCH) begin
        r_port  <= i_io_port;
        r_wr    <= i_io_wr;
        r_wdata <= i_io_wdata;
      end
      if (w_exec_rd) r_rdata <= w_rdata_mux;
      // Rise pulses live for exactly the ACK cycle that follows EXEC.
      r_snd1_rise <= '0;
      r_snd2_rise <= '0;
      if (w_exec_wr && r_port == PORT_SND1) begin
        r_snd1      <= r_wdata;
        r_snd1_rise <= r_wdata & ~r_snd1;
      end
      if (w_exec_wr && r_port == PORT_SND2) begin
        r_snd2      <= r_wdata;
        r_snd2_rise <= r_wdata & ~r_snd2;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog_cnt   <= '0;
      r_wdog_pulse <= 1'b0;
    end else if (w_kick) begin
      r_wdog_cnt   <= '0;
      r_wdog_pulse <= 1'b0;
    end else if (r_wdog_cnt == WDOG_TC) begin
      r_wdog_cnt   <= '0;
      r_wdog_pulse <= 1'b1;
    end else begin
      r_wdog_cnt   <= r_wdog_cnt + WDOG_ONE;
      r_wdog_pulse <= 1'b0;
    end
  end

  assign o_io_ack          = (r_state == ST_ACK);
  assign o_io_rdata        = r_rdata;
  assign o_shift_wr_data   = w_exec_wr && (r_port == PORT_SHIFT_DAT);
  assign o_shift_wr_offset = w_exec_wr && (r_port == PORT_SHIFT_OFS);
  assign o_shift_data      = r_wdata;
  assign o_snd1            = r_snd1;
  assign o_snd2            = r_snd2;
  assign o_snd1_rise       = r_snd1_rise;
  assign o_snd2_rise       = r_snd2_rise;
  assign o_wdog_reset      = r_wdog_pulse;

endmodule

// File: tb/tb_invaders_io_bridge.sv
// tb/tb_invaders_io_bridge.sv - self-checking bench for invaders_io_bridge
module tb_invaders_io_bridge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] port = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] in0 = 8'h00, in1 = 8'h00, in2 = 8'h00;
  logic       ack;
  logic [7:0] rdata;
  logic       shift_wr_data, shift_wr_offset;
  logic [7:0] shift_data, shift_rdata;
  logic [7:0] snd1, snd2, snd1_rise, snd2_rise;
  logic       wdog_reset;

  invaders_io_bridge #(.WDOG_BITS(4)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_io_req         (req),
    .i_io_wr          (wr),
    .i_io_port        (port),
    .i_io_wdata       (wdata),
    .o_io_ack         (ack),
    .o_io_rdata       (rdata),
    .i_in0            (in0),
    .i_in1            (in1),
    .i_in2            (in2),
    .o_shift_wr_data  (shift_wr_data),
    .o_shift_wr_offset(shift_wr_offset),
    .o_shift_data     (shift_data),
    .i_shift_rdata    (shift_rdata),
    .o_snd1           (snd1),
    .o_snd2           (snd2),
    .o_snd1_rise      (snd1_rise),
    .o_snd2_rise      (snd2_rise),
    .o_wdog_reset     (wdog_reset)
  );

  always #5 clk = ~clk;

  // Attached hardware shifter: 16-bit register, new byte enters at the top.
  logic [15:0] sh_reg = 16'h0000;
  logic [2:0]  sh_ofs = 3'd0;
  logic [15:0] sh_tmp;
  always @(posedge clk) begin
    if (shift_wr_data)   sh_reg <= {shift_data, sh_reg[15:8]};
    if (shift_wr_offset) sh_ofs <= shift_data[2:0];
  end
  assign sh_tmp      = sh_reg << sh_ofs;
  assign shift_rdata = sh_tmp[15:8];

  // Shadow of the shifter driven from stimulus, used to predict IN 3.
  logic [15:0] sd_reg = 16'h0000;
  logic [2:0]  sd_ofs = 3'd0;
  function automatic logic [7:0] shadow_rd();
    logic [15:0] t;
    t = sd_reg << sd_ofs;
    return t[15:8];
  endfunction

  int cyc = 0;
  int n_sd = 0, n_so = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (shift_wr_data)   n_sd <= n_sd + 1;
    if (shift_wr_offset) n_so <= n_so + 1;
  end

  typedef struct {
    bit         is_rd;
    logic [7:0] exp;
  } exp_t;
  exp_t sb_q[$];

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] cap_snd1, cap_snd2, cap_rise1, cap_rise2;

  task automatic io_txn(input bit t_wr, input logic [7:0] t_port, input logic [7:0] t_wdata,
                        input logic [7:0] t_exp, input int t_hold, input bit t_chg_in1);
    exp_t e;
    int   lat;
    bit   got;
    e.is_rd = !t_wr;
    e.exp   = t_exp;
    sb_q.push_back(e);
    if (t_wr && t_port == 8'd4) sd_reg = {t_wdata, sd_reg[15:8]};
    if (t_wr && t_port == 8'd2) sd_ofs = t_wdata[2:0];
    @(posedge clk); #1;
    req = 1'b1; wr = t_wr; port = t_port; wdata = t_wdata;
    got = 1'b0; lat = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (t_chg_in1 && i == 2) in1 = 8'h81;
      if (ack) begin got = 1'b1; lat = i; end
    end
    vectors++;
    if (!got) begin
      $display("FAIL ack_timeout port=%0d: ack=0 after 20 cycles, required ack=1", t_port);
      miscompares++;
      req = 1'b0;
      void'(sb_q.pop_front());
      return;
    end
    cap_snd1 = snd1; cap_snd2 = snd2; cap_rise1 = snd1_rise; cap_rise2 = snd2_rise;
    vectors++;
    if (lat !== 4) begin
      $display("FAIL ack_latency port=%0d: got %0d cycles, required 4", t_port, lat);
      miscompares++;
    end
    e = sb_q.pop_front();
    if (e.is_rd) begin
      vectors++;
      if (rdata !== e.exp) begin
        $display("FAIL rdata port=%0d: got %h, required %h", t_port, rdata, e.exp);
        miscompares++;
      end
    end
    for (int i = 0; i < t_hold; i++) begin
      @(negedge clk);
      vectors++;
      if (ack !== 1'b0) begin
        $display("FAIL ack_repeat port=%0d: ack=%b during held request, required 0", t_port, ack);
        miscompares++;
      end
    end
    req = 1'b0;
    @(negedge clk);
    vectors++;
    if (ack !== 1'b0) begin
      $display("FAIL ack_width port=%0d: ack=%b after ack cycle, required 0", t_port, ack);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    logic [67:0] outs;
    int sd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {ack, rdata, shift_wr_data, shift_wr_offset, shift_data, snd1, snd2,
            snd1_rise, snd2_rise, wdog_reset, 16'h0000};
    vectors++;
    if (outs !== 68'h0) begin
      $display("FAIL reset_outputs: got %h, required 0", outs);
      miscompares++;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    // Interrupt an OUT 4 while it is in EXEC.
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; port = 8'd4; wdata = 8'hC3;
    repeat (3) @(negedge clk);
    vectors++;
    if (shift_wr_data !== 1'b1) begin
      $display("FAIL exec_strobe: got %b, required 1", shift_wr_data);
      miscompares++;
    end
    sd0 = n_sd;
    rst_n = 1'b0;
    #1;
    outs = {ack, rdata, shift_wr_data, shift_wr_offset, shift_data, snd1, snd2,
            snd1_rise, snd2_rise, wdog_reset, 16'h0000};
    vectors++;
    if (outs !== 68'h0) begin
      $display("FAIL reset_mid_exec: got %h, required 0", outs);
      miscompares++;
    end
    req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (ack !== 1'b0 || n_sd !== sd0) begin
        $display("FAIL dropped_txn: ack=%b strobes=%0d, required ack=0 strobes=%0d", ack, n_sd, sd0);
        miscompares++;
      end
    end
  endtask

  task automatic test_shift();
    int sd0, so0;
    sd0 = n_sd; so0 = n_so;
    io_txn(1'b1, 8'd4, 8'hAA, 8'h00, 0, 1'b0);
    io_txn(1'b1, 8'd4, 8'h55, 8'h00, 0, 1'b0);
    io_txn(1'b1, 8'd2, 8'h03, 8'h00, 0, 1'b0);
    io_txn(1'b0, 8'd3, 8'h00, shadow_rd(), 0, 1'b0);
    io_txn(1'b1, 8'd2, 8'h00, 8'h00, 0, 1'b0);
    io_txn(1'b0, 8'd3, 8'h00, shadow_rd(), 0, 1'b0);
    io_txn(1'b1, 8'd2, 8'h07, 8'h00, 0, 1'b0);
    io_txn(1'b0, 8'd3, 8'h00, shadow_rd(), 0, 1'b0);
    vectors++;
    if (n_sd - sd0 !== 2 || n_so - so0 !== 3) begin
      $display("FAIL strobe_count: data=%0d ofs=%0d, required data=2 ofs=3", n_sd - sd0, n_so - so0);
      miscompares++;
    end
  endtask

  task automatic test_sound();
    io_txn(1'b1, 8'd3, 8'h05, 8'h00, 10, 1'b0);
    vectors++;
    if (cap_snd1 !== 8'h05 || cap_rise1 !== 8'h05) begin
      $display("FAIL snd1_first: snd=%h rise=%h, required snd=05 rise=05", cap_snd1, cap_rise1);
      miscompares++;
    end
    vectors++;
    if (snd1_rise !== 8'h00 || snd1 !== 8'h05) begin
      $display("FAIL snd1_after: snd=%h rise=%h, required snd=05 rise=00", snd1, snd1_rise);
      miscompares++;
    end
    io_txn(1'b1, 8'd3, 8'h06, 8'h00, 0, 1'b0);
    vectors++;
    if (cap_snd1 !== 8'h06 || cap_rise1 !== 8'h02) begin
      $display("FAIL snd1_second: snd=%h rise=%h, required snd=06 rise=02", cap_snd1, cap_rise1);
      miscompares++;
    end
    io_txn(1'b1, 8'd5, 8'hF0, 8'h00, 2, 1'b0);
    vectors++;
    if (cap_snd2 !== 8'hF0 || cap_rise2 !== 8'hF0 || cap_rise1 !== 8'h00 || snd1 !== 8'h06) begin
      $display("FAIL snd2: snd2=%h rise2=%h rise1=%h snd1=%h, required F0 F0 00 06",
               cap_snd2, cap_rise2, cap_rise1, snd1);
      miscompares++;
    end
  endtask

  task automatic test_inputs();
    logic [7:0] s1, s2;
    int sd0, so0;
    in0 = 8'h3C; in2 = 8'hA5;
    repeat (3) @(posedge clk);
    io_txn(1'b0, 8'd0, 8'h00, 8'h3C, 0, 1'b0);
    io_txn(1'b0, 8'd2, 8'h00, 8'hA5, 0, 1'b0);
    // in1 changes while this read is in LATCH: too late to pass the synchronizer.
    io_txn(1'b0, 8'd1, 8'h00, 8'h00, 0, 1'b1);
    io_txn(1'b0, 8'd1, 8'h00, 8'h81, 0, 1'b0);
    io_txn(1'b0, 8'd7, 8'h00, 8'h00, 0, 1'b0);
    s1 = snd1; s2 = snd2; sd0 = n_sd; so0 = n_so;
    io_txn(1'b1, 8'd9, 8'hFF, 8'h00, 0, 1'b0);
    vectors++;
    if (snd1 !== s1 || snd2 !== s2 || n_sd !== sd0 || n_so !== so0) begin
      $display("FAIL out9_side_effect: snd1=%h snd2=%h strobes=%0d/%0d, required %h %h %0d/%0d",
               snd1, snd2, n_sd, n_so, s1, s2, sd0, so0);
      miscompares++;
    end
  endtask

  task automatic test_wdog();
    int t1, t2, pc, ac;
    bit got;
    t1 = -1; t2 = -1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (wdog_reset) begin got = 1'b1; t1 = cyc; end
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (wdog_reset) begin got = 1'b1; t2 = cyc; end
    end
    vectors++;
    if (t1 < 0 || t2 < 0 || t2 - t1 !== 15) begin
      $display("FAIL wdog_period: got %0d cycles, required 15", t2 - t1);
      miscompares++;
    end
    // Land the kick's EXEC on the terminal-count cycle.
    repeat (12) @(posedge clk);
    #1;
    req = 1'b1; wr = 1'b1; port = 8'd6; wdata = 8'h00;
    pc = 0; ac = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (ack) begin ac++; req = 1'b0; end
      if (wdog_reset) pc++;
    end
    req = 1'b0;
    vectors++;
    if (pc !== 0 || ac !== 1) begin
      $display("FAIL wdog_kick_wins: pulses=%0d acks=%0d, required pulses=0 acks=1", pc, ac);
      miscompares++;
    end
    got = 1'b0; t1 = -1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (wdog_reset) begin got = 1'b1; t1 = cyc; end
    end
    vectors++;
    if (t1 !== t2 + 30) begin
      $display("FAIL wdog_after_kick: pulse at cycle %0d, required %0d", t1, t2 + 30);
      miscompares++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_shift();
    test_sound();
    test_inputs();
    test_wdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
